// File: rtl/mips_cpu_mult_div_if.sv
// Request/response bundle between the ALU control stage and the mult/div unit.
interface mips_cpu_mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdata;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, rdata
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, rdata
  );
endinterface

// File: rtl/mips_cpu_mult_div.sv
// Iterative multiply/divide unit owning HI/LO. One bit per cycle:
// shift-add multiply, restoring shift-subtract divide, sign fix-up at the end.
module mips_cpu_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  mips_cpu_mult_div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [2:0] OP_MFHI = 3'b110;
  localparam logic [2:0] OP_MFLO = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_e;

  state_e             state_q, state_d;
  logic               is_signed_q, is_signed_d;
  logic               is_mult_q, is_mult_d;
  logic [WIDTH-1:0]   a_q, a_d;          // raw operands as issued
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   m_q, m_d;          // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {product} or {remainder, quotient}
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;      // product / quotient sign
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  // Operand magnitudes and the per-bit add / trial-subtract datapath.
  always_comb begin
    a_mag     = (is_signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag     = (is_signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
    add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : {WIDTH{1'b0}})};
    div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    // Top bit set means the trial went negative: restore (keep trial).
    div_diff  = div_trial - {1'b0, m_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
  end

  // Next-state and datapath updates for the IDLE/PREP/ITER/FIX sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    is_signed_d = is_signed_q;
    is_mult_d   = is_mult_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    rem_neg_d   = rem_neg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            a_d         = bus.a;
            b_d         = bus.b;
            is_signed_d = bus.op[1];
            is_mult_d   = bus.op[0];
            state_d     = S_PREP;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      S_PREP: begin
        neg_d     = is_signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rem_neg_d = is_signed_q & a_q[WIDTH-1];
        m_d       = is_mult_q ? a_mag : b_mag;
        acc_d     = {{WIDTH{1'b0}}, (is_mult_q ? b_mag : a_mag)};
        cnt_d     = CW'(WIDTH);
        state_d   = S_ITER;
      end
      S_ITER: begin
        if (is_mult_q) begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end else if (div_diff[WIDTH]) begin
          acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_mult_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_q == '0) begin
          hi_d = a_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          lo_d = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
          hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the datapath registers are reset too, so an aborted op leaves no stale operands behind.
    if (!reset_n) begin
      state_q     <= S_IDLE;
      is_signed_q <= 1'b0;
      is_mult_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples the pre-edge values.
      state_q     <= state_d;
      is_signed_q <= is_signed_d;
      is_mult_q   <= is_mult_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      rem_neg_q   <= rem_neg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
    end
  end

  // MFHI/MFLO read path, purely combinational on the requested op.
  always_comb begin
    bus.rdata = '0;
    if (bus.op == OP_MFHI) bus.rdata = hi_q;
    else if (bus.op == OP_MFLO) bus.rdata = lo_q;
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// Scoreboard bench for mips_cpu_mult_div: stimulus pushes expected HI/LO and
// due cycle; a monitor pops and compares on every done pulse.
module tb_mips_cpu_mult_div;

  localparam int W       = 32;
  localparam int LATENCY = W + 2;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_compared;
  int   n_mismatched;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  exp_t sb[$];

  mips_cpu_mult_div_if #(.WIDTH(W)) bus ();

  mips_cpu_mult_div #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_hi", bus.hi, e.hi);
        check("sb_lo", bus.lo, e.lo);
        check("sb_latency_cycle", cyc, e.due);
      end
    end
  end

  // Drive one start cycle from a negedge; optionally record the expected result.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.due = cyc + LATENCY + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Bounded wait for a done pulse; returns at the negedge where done is seen.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s_timeout: got no done in 60 cycles expected done", name);
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit saw_done;

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    reset_n   = 1'b0;
    n_compared   = 0;
    n_mismatched = 0;

    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors: op, a, b, expected hi, expected lo.
    vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{3'b011, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{3'b000, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF});
    vecs.push_back('{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{3'b000, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E});
    vecs.push_back('{3'b001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780});
    vecs.push_back('{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].hi, vecs[i].lo);
      check("busy_in_flight", bus.busy, 1);
      wait_done("vec");
      check("busy_in_done_cycle", bus.busy, 0);
      @(negedge clk);
    end

    // MTHI/MTLO write at the accepting edge and never raise busy.
    issue(3'b100, 32'h0000_1234, '0, 1'b0, '0, '0);
    check("mthi_busy", bus.busy, 0);
    check("mthi_hi", bus.hi, 32'h0000_1234);
    issue(3'b101, 32'h0000_5678, '0, 1'b0, '0, '0);
    check("mtlo_busy", bus.busy, 0);
    check("mtlo_lo", bus.lo, 32'h0000_5678);
    check("mtlo_hi_kept", bus.hi, 32'h0000_1234);
    bus.op = 3'b110;
    #1 check("mfhi_rdata", bus.rdata, 32'h0000_1234);
    bus.op = 3'b111;
    #1 check("mflo_rdata", bus.rdata, 32'h0000_5678);
    bus.op = 3'b000;
    #1 check("rdata_other_op", bus.rdata, 0);
    @(negedge clk);

    // Start while busy is ignored; back-to-back start in the done cycle is accepted.
    issue(3'b001, 32'd3, 32'd5, 1'b1, 32'h0, 32'd15);
    repeat (5) @(negedge clk);
    check("busy_mid_op", bus.busy, 1);
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 32'h0000_DEAD;
    @(negedge clk);
    bus.start = 1'b0;
    check("ignored_mthi_hi", bus.hi, 32'h0000_1234);
    bus.op = 3'b110;
    #1 check("mfhi_while_busy", bus.rdata, 32'h0000_1234);
    wait_done("ignored");
    issue(3'b001, 32'd6, 32'd7, 1'b1, 32'h0, 32'd42);
    check("b2b_busy", bus.busy, 1);
    wait_done("b2b");
    @(negedge clk);

    // Reset mid-divide aborts: state cleared, no done pulse later.
    issue(3'b100, 32'h0000_AAAA, '0, 1'b0, '0, '0);
    issue(3'b101, 32'h0000_BBBB, '0, 1'b0, '0, '0);
    issue(3'b000, 32'd100, 32'd7, 1'b0, '0, '0);
    repeat (9) @(negedge clk);
    check("pre_abort_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_lo", bus.lo, 0);
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_busy_after", bus.busy, 0);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
